// File: rtl/optic_flow_accu_ci.sv
// Pipelined optic-flow custom instruction: 8 pixels of {up,down,left,right} flow per call,
// horizontal neighbour chained across calls, saturating per-direction vote counters.
module optic_flow_accu_ci #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter logic [7:0] ctrlInstructionId   = 8'd1,
    parameter int         COUNT_WIDTH         = 16,
    parameter bit         CHAIN_ENABLE        = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result
);
    localparam int SUM_WIDTH = ((COUNT_WIDTH > 4) ? COUNT_WIDTH : 4) + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   done_q, done_d;
    logic [31:0]            result_q, result_d;
    logic [COUNT_WIDTH-1:0] cnt_q [4];
    logic [COUNT_WIDTH-1:0] cnt_d [4];
    logic [3:0]             sat_q, sat_d;
    logic [1:0]             chain_q, chain_d;
    logic                   chain_valid_q, chain_valid_d;

    logic                   is_comp, is_ctrl;
    logic [15:0]            cur_up, cur_dn, prv_up, prv_dn;
    logic                   chain_use;
    logic [8:0]             cx, px;
    logic [31:0]            flow;
    logic [3:0]             pop [4];
    logic [SUM_WIDTH-1:0]   sum [4];
    logic [COUNT_WIDTH-1:0] cnt_add [4];
    logic [3:0]             sat_hit;
    logic                   unused_dn_x;

    assign is_comp = start && (ciN == customInstructionId);
    assign is_ctrl = start && (ciN == ctrlInstructionId);

    assign cur_up = valueA[31:16];
    assign cur_dn = valueA[15:0];
    assign prv_up = valueB[31:16];
    assign prv_dn = valueB[15:0];

    // Down-row x bits carry no flow information.
    assign unused_dn_x = ^{cur_dn[14], cur_dn[12], cur_dn[10], cur_dn[8], cur_dn[6], cur_dn[4], cur_dn[2], cur_dn[0],
                           prv_dn[14], prv_dn[12], prv_dn[10], prv_dn[8], prv_dn[6], prv_dn[4], prv_dn[2], prv_dn[0]};

    // Index 8 is the neighbour right of pixel 7, taken from the previous call of the row.
    assign chain_use = CHAIN_ENABLE && chain_valid_q;
    assign cx[8]     = chain_use ? chain_q[1] : 1'b0;
    assign px[8]     = chain_use ? chain_q[0] : 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pix
            logic left_and, right_and, up_and, down_and;
            assign cx[gi]     = cur_up[2*gi];
            assign px[gi]     = prv_up[2*gi];
            assign left_and   = cx[gi] & px[gi+1];
            assign right_and  = cx[gi+1] & px[gi];
            assign up_and     = cur_up[2*gi+1] & prv_dn[2*gi+1];
            assign down_and   = cur_dn[2*gi+1] & prv_up[2*gi+1];
            assign flow[4*gi +: 4] = {up_and & ~down_and, down_and & ~up_and,
                                      left_and & ~right_and, right_and & ~left_and};
        end
    endgenerate

    // Direction d of every pixel lives at flow bit 4*i+d, matching the counter index.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            pop[d] = '0;
            for (int i = 0; i < 8; i++) begin
                pop[d] = pop[d] + 4'(flow[4*i+d]);
            end
            sum[d]     = SUM_WIDTH'(cnt_q[d]) + SUM_WIDTH'(pop[d]);
            sat_hit[d] = sum[d] > SUM_WIDTH'(CNT_MAX);
            cnt_add[d] = sat_hit[d] ? CNT_MAX : sum[d][COUNT_WIDTH-1:0];
        end
    end

    always_comb begin
        done_d        = is_comp | is_ctrl;
        result_d      = '0;
        cnt_d         = cnt_q;
        sat_d         = sat_q;
        chain_d       = chain_q;
        chain_valid_d = chain_valid_q;
        if (is_comp) begin
            result_d = flow;
            cnt_d    = cnt_add;
            sat_d    = sat_q | sat_hit;
            if (CHAIN_ENABLE) begin
                chain_d       = {cur_up[0], prv_up[0]};
                chain_valid_d = 1'b1;
            end
        end else if (is_ctrl) begin
            case (valueA[2:0])
                3'd0: result_d = 32'(cnt_q[valueB[1:0]]);
                3'd1: begin
                    for (int d = 0; d < 4; d++) begin
                        cnt_d[d] = '0;
                    end
                    sat_d         = '0;
                    chain_valid_d = 1'b0;
                end
                3'd2: chain_valid_d = 1'b0;
                3'd3: result_d = {27'd0, chain_valid_q, sat_q};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            done_q        <= 1'b0;
            result_q      <= '0;
            sat_q         <= '0;
            chain_q       <= '0;
            chain_valid_q <= 1'b0;
            for (int d = 0; d < 4; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            done_q        <= done_d;
            result_q      <= result_d;
            sat_q         <= sat_d;
            chain_q       <= chain_d;
            chain_valid_q <= chain_valid_d;
            for (int d = 0; d < 4; d++) begin
                cnt_q[d] <= cnt_d[d];
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_optic_flow_accu_ci.sv
// Scoreboard bench for optic_flow_accu_ci: three instances (default, chain disabled,
// 4-bit counters) driven from one stimulus stream, checked against a behavioural model.
module tb_optic_flow_accu_ci;
    logic        clk;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [31:0] value_a, value_b;
    logic [7:0]  ci_n;
    logic        done_a, done_b, done_c;
    logic [31:0] result_a, result_b, result_c;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_on       = 0;

    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] exp_c [$];

    // model state per instance: 0 = default, 1 = chain off, 2 = 4-bit counters
    int       m_cnt   [3][4];
    bit       m_sat   [3][4];
    bit [1:0] m_chain [3];
    bit       m_cv    [3];
    int       m_cw    [3] = '{16, 16, 4};
    bit       m_ce    [3] = '{1'b1, 1'b0, 1'b1};

    optic_flow_accu_ci dut_a (
        .clock(clk), .reset(rst_n), .start(start_a), .valueA(value_a), .valueB(value_b),
        .ciN(ci_n), .done(done_a), .result(result_a)
    );
    optic_flow_accu_ci #(.CHAIN_ENABLE(1'b0)) dut_b (
        .clock(clk), .reset(rst_n), .start(start_b), .valueA(value_a), .valueB(value_b),
        .ciN(ci_n), .done(done_b), .result(result_b)
    );
    optic_flow_accu_ci #(.COUNT_WIDTH(4)) dut_c (
        .clock(clk), .reset(rst_n), .start(start_c), .valueA(value_a), .valueB(value_b),
        .ciN(ci_n), .done(done_c), .result(result_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 4; d++) begin
                m_cnt[k][d] = 0;
                m_sat[k][d] = 1'b0;
            end
            m_chain[k] = 2'b00;
            m_cv[k]    = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_exec(input int k, input logic [7:0] ci,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [15:0] cu, cd, pu, pd;
        int          votes [4];
        int          s, mx;
        r = 32'd0;
        cu = a[31:16]; cd = a[15:0]; pu = b[31:16]; pd = b[15:0];
        if (ci == 8'd0) begin
            for (int d = 0; d < 4; d++) votes[d] = 0;
            for (int i = 0; i < 8; i++) begin
                logic cxn, pxn, la, ra, ua, da;
                logic [3:0] nib;
                if (i < 7) begin
                    cxn = cu[2*i+2]; pxn = pu[2*i+2];
                end else if (m_ce[k] && m_cv[k]) begin
                    cxn = m_chain[k][1]; pxn = m_chain[k][0];
                end else begin
                    cxn = 1'b0; pxn = 1'b0;
                end
                la  = cu[2*i] & pxn;
                ra  = cxn & pu[2*i];
                ua  = cu[2*i+1] & pd[2*i+1];
                da  = cd[2*i+1] & pu[2*i+1];
                nib = {ua && !da, da && !ua, la && !ra, ra && !la};
                r[4*i +: 4] = nib;
                for (int d = 0; d < 4; d++) if (nib[d]) votes[d]++;
            end
            mx = (1 << m_cw[k]) - 1;
            for (int d = 0; d < 4; d++) begin
                s = m_cnt[k][d] + votes[d];
                if (s > mx) begin
                    m_cnt[k][d] = mx;
                    m_sat[k][d] = 1'b1;
                end else begin
                    m_cnt[k][d] = s;
                end
            end
            if (m_ce[k]) begin
                m_chain[k] = {cu[0], pu[0]};
                m_cv[k]    = 1'b1;
            end
        end else begin
            case (a[2:0])
                3'd0: r = 32'(m_cnt[k][b[1:0]]);
                3'd1: begin
                    for (int d = 0; d < 4; d++) begin
                        m_cnt[k][d] = 0;
                        m_sat[k][d] = 1'b0;
                    end
                    m_cv[k] = 1'b0;
                end
                3'd2: m_cv[k] = 1'b0;
                3'd3: r = {27'd0, m_cv[k], m_sat[k][3], m_sat[k][2], m_sat[k][1], m_sat[k][0]};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    // Called right after a falling edge; the request is sampled on the next rising edge.
    task automatic issue(input int k, input logic [7:0] ci, input logic [31:0] a,
                         input logic [31:0] b, input logic rst_val);
        logic [31:0] e;
        value_a = a; value_b = b; ci_n = ci; rst_n = rst_val;
        start_a = (k == 0); start_b = (k == 1); start_c = (k == 2);
        if (!rst_val) begin
            model_reset();
        end else if (ci == 8'd0 || ci == 8'd1) begin
            e = model_exec(k, ci, a, b);
            case (k)
                0: exp_a.push_back(e);
                1: exp_b.push_back(e);
                default: exp_c.push_back(e);
            endcase
        end
        @(negedge clk);
    endtask

    task automatic comp(input int k, input logic [31:0] a, input logic [31:0] b);
        issue(k, 8'd0, a, b, 1'b1);
    endtask

    task automatic ctrl(input int k, input logic [31:0] op, input logic [31:0] b);
        issue(k, 8'd1, op, b, 1'b1);
    endtask

    task automatic idle(input int n);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; rst_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_all(input int k);
        for (int d = 0; d < 4; d++) ctrl(k, 32'd0, 32'(d));
        ctrl(k, 32'd3, 32'd0);
    endtask

    task automatic mon(input string name, input int k, input logic d, input logic [31:0] r);
        logic [31:0] e;
        bit          have;
        have = 1'b0; e = 32'd0;
        case (k)
            0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
            1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
            default: if (exp_c.size() > 0) begin e = exp_c.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            $display("[TB] %s done result=%h expected=%h", name, r, e);
            check_val({name, ".done"}, {31'd0, d}, 32'd1);
            check_val({name, ".result"}, r, e);
        end else begin
            check_val({name, ".done_idle"}, {31'd0, d}, 32'd0);
            check_val({name, ".result_idle"}, r, 32'd0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            mon("dut_a", 0, done_a, result_a);
            mon("dut_b", 1, done_b, result_b);
            mon("dut_c", 2, done_c, result_c);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        value_a = 32'd0; value_b = 32'd0; ci_n = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        idle(2);

        // reset state, then first compute sets only chain_valid
        read_all(0);
        comp(0, 32'h0001_0000, 32'h0000_0000);
        read_all(0);

        // clear, then eight down votes
        ctrl(0, 32'd1, 32'd0);
        comp(0, 32'h0000_AAAA, 32'hAAAA_0000);
        ctrl(0, 32'd0, 32'd2);
        idle(1);

        // up/down conflict gives no flow and leaves counters alone
        comp(0, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        read_all(0);

        // foreign ID and spare ctrl opcodes
        issue(0, 8'h05, 32'h0000_AAAA, 32'hAAAA_0000, 1'b1);
        idle(1);
        for (int op = 4; op < 8; op++) ctrl(0, 32'(op), 32'd0);
        read_all(0);

        // chain: right via carried neighbour, then left via carried neighbour
        for (int k = 0; k < 2; k++) begin
            ctrl(k, 32'd2, 32'd0);
            comp(k, 32'h0001_0000, 32'h0000_0000);
            comp(k, 32'h0000_0000, 32'h4000_0000);
            comp(k, 32'h0000_0000, 32'h0001_0000);
            comp(k, 32'h4000_0000, 32'h0000_0000);
            ctrl(k, 32'd3, 32'd0);
            ctrl(k, 32'd2, 32'd0);
            comp(k, 32'h0000_0000, 32'h4000_0000);
            idle(1);
        end

        // 4-bit counters: 8 fits, 16 saturates to 15
        ctrl(2, 32'd1, 32'd0);
        comp(2, 32'h0000_AAAA, 32'hAAAA_0000);
        read_all(2);
        comp(2, 32'h0000_AAAA, 32'hAAAA_0000);
        read_all(2);
        idle(1);

        // back-to-back compute, compute, read
        ctrl(0, 32'd1, 32'd0);
        comp(0, 32'hAAAA_0000, 32'h0000_AAAA);
        comp(0, 32'hAAAA_0000, 32'h0000_AAAA);
        ctrl(0, 32'd0, 32'd3);
        idle(1);

        // reset asserted together with the second start
        comp(0, 32'hAAAA_0000, 32'h0000_AAAA);
        issue(0, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, 1'b0);
        idle(1);
        read_all(0);
        read_all(1);
        read_all(2);

        // random mix across instances
        for (int n = 0; n < 60; n++) begin
            int k, sel;
            k   = $urandom_range(0, 2);
            sel = $urandom_range(0, 9);
            if (sel < 6)      comp(k, $urandom, $urandom);
            else if (sel < 9) ctrl(k, $urandom, $urandom);
            else              issue(k, 8'h2A, $urandom, $urandom, 1'b1);
        end
        for (int k = 0; k < 3; k++) read_all(k);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
